// File: rtl/jedro_1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jedro_1_pkg
//  Description : Shared opcodes, funct fields, ALU ops and decoded-instruction
//                record for the jedro_1 RV32I core.
//  Revision    : 1.0
// ============================================================================
package jedro_1_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef struct packed {
    logic            valid;
    alu_op_e         op;
    logic            use_imm;
    logic            use_pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } dec_t;

  // alt selects SUB/SRA; callers pass it only where funct7 is meaningful
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jedro_1_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : jedro_1_decoder
//  Description : ID stage: registers the fetched word, decodes it and registers
//                the decoded record; raises the sticky illegal-instruction flag.
//  Revision    : 1.0
// ============================================================================
module jedro_1_decoder
  import jedro_1_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_valid_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic [XLEN-1:0] instr_i,
  output dec_t            dec_o,
  output logic            illegal_instr_ro
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  dec_t            dec_d;
  dec_t            dec_q;
  logic            illegal_d;

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_opcode = instr_q[6:0];
  assign w_f3     = instr_q[14:12];
  assign w_f7     = instr_q[31:25];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q          <= 1'b0;
      instr_q          <= '0;
      pc_q             <= '0;
      dec_q            <= '0;
      illegal_instr_ro <= 1'b0;
    end else begin
      valid_q          <= fetch_valid_i && !illegal_instr_ro;
      instr_q          <= instr_i;
      pc_q             <= fetch_pc_i;
      dec_q            <= dec_d;
      illegal_instr_ro <= illegal_instr_ro || (valid_q && illegal_d);
    end
  end

  always_comb begin
    dec_d         = '0;
    illegal_d     = 1'b0;
    dec_d.rd      = instr_q[11:7];
    dec_d.rs1     = instr_q[19:15];
    dec_d.rs2     = instr_q[24:20];
    dec_d.pc      = pc_q;
    dec_d.op      = ALU_ADD;
    case (w_opcode)
      OPC_OP_IMM: begin
        dec_d.use_imm = 1'b1;
        dec_d.imm     = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
        dec_d.op      = f3_to_alu(w_f3, (w_f3 == F3_SRL_SRA) && (w_f7 == F7_ALT));
        if ((w_f3 == F3_SLL) && (w_f7 != F7_BASE)) illegal_d = 1'b1;
        if ((w_f3 == F3_SRL_SRA) && (w_f7 != F7_BASE) && (w_f7 != F7_ALT)) illegal_d = 1'b1;
      end
      OPC_OP: begin
        dec_d.op = f3_to_alu(w_f3, w_f7 == F7_ALT);
        if (!((w_f7 == F7_BASE) ||
              ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SRL_SRA)))))
          illegal_d = 1'b1;
      end
      OPC_LUI: begin
        dec_d.use_imm = 1'b1;
        dec_d.imm     = {instr_q[31:12], 12'b0};
        dec_d.op      = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        dec_d.use_imm = 1'b1;
        dec_d.use_pc  = 1'b1;
        dec_d.imm     = {instr_q[31:12], 12'b0};
        dec_d.op      = ALU_ADD;
      end
      default: illegal_d = 1'b1;
    endcase
    // anything younger than a detected illegal word is squashed here
    dec_d.valid = valid_q && !illegal_d && !illegal_instr_ro;
  end

  assign dec_o = dec_q;

endmodule
`default_nettype wire

// File: rtl/jedro_1_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : jedro_1_regfile
//  Description : 32 x XLEN integer register file, two async read ports, one
//                synchronous write port; x0 hard-wired to zero.
//  Revision    : 1.0
// ============================================================================
module jedro_1_regfile
  import jedro_1_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] regfile [0:31];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regfile[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regfile[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regfile[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regfile[raddr2_i];

endmodule
`default_nettype wire

// File: rtl/jedro_1_top.sv
`default_nettype none
// ============================================================================
//  Module      : jedro_1_top
//  Description : Minimal in-order RV32I core, IF -> ID -> EX/WB, register-
//                immediate/register-register/LUI/AUIPC; halts on illegal words.
//  Revision    : 1.0
// ============================================================================
module jedro_1_top
  import jedro_1_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = 32'h0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [3:0]            data_we_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i,
  output logic                  illegal_instr_o
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic                  fetch_valid_q;
  logic                  halt;
  dec_t                  dec;
  logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
  logic [DATA_WIDTH-1:0] op_a, op_b, alu_res;
  logic [4:0]            shamt;
  logic                  unused_data;

  // IF: one word issued per cycle; the valid bit tracks the ROM's read latency
  always_comb begin
    pc_d = halt ? pc_q : pc_q + ADDR_WIDTH'(4);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= BOOT_ADDR;
      fetch_pc_q    <= BOOT_ADDR;
      fetch_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_pc_q    <= pc_q;
      fetch_valid_q <= !halt;
    end
  end

  assign instr_addr_o = pc_q;

  jedro_1_decoder decoder_inst (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .fetch_valid_i    (fetch_valid_q),
    .fetch_pc_i       (fetch_pc_q),
    .instr_i          (instr_rdata_i),
    .dec_o            (dec),
    .illegal_instr_ro (halt)
  );

  jedro_1_regfile regfile_inst (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (dec.valid && (dec.rd != 5'd0)),
    .waddr_i  (dec.rd),
    .wdata_i  (alu_res),
    .raddr1_i (dec.rs1),
    .raddr2_i (dec.rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  // EX/WB: operands come straight from the regfile, so no forwarding is needed
  assign op_a  = dec.use_pc  ? dec.pc  : rs1_data;
  assign op_b  = dec.use_imm ? dec.imm : rs2_data;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (dec.op)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_SLL:    alu_res = op_a << shamt;
      ALU_SLT:    alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   alu_res = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SRL:    alu_res = op_a >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_PASS_B: alu_res = op_b;
      default:    alu_res = '0;
    endcase
  end

  assign illegal_instr_o = halt;

  assign data_addr_o  = '0;
  assign data_we_o    = 4'b0000;
  assign data_wdata_o = '0;
  assign unused_data  = ^data_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jedro_1_top
//  Description : Directed-program bench for jedro_1_top with a write-back
//                scoreboard fed by the stimulus and drained by a monitor.
//  Revision    : 1.0
// ============================================================================
module tb_jedro_1_top;

  localparam logic [6:0] OPI = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_addr, instr_rdata, data_addr, data_wdata;
  logic [3:0]  data_we;
  logic        illegal;

  logic [31:0] rom [0:63];

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;
  wr_t exp_q[$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  jedro_1_top dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_addr_o    (instr_addr),
    .instr_rdata_i   (instr_rdata),
    .data_addr_o     (data_addr),
    .data_we_o       (data_we),
    .data_wdata_o    (data_wdata),
    .data_rdata_i    (32'hDEAD_BEEF),
    .illegal_instr_o (illegal)
  );

  always @(posedge clk) instr_rdata <= rom[instr_addr[7:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every architectural register write is matched against the queue
  always @(negedge clk) begin
    if (mon_en && dut.regfile_inst.we_i && dut.regfile_inst.waddr_i != 5'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: x%0d <= %08h with empty queue",
                 dut.regfile_inst.waddr_i, dut.regfile_inst.wdata_i);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wb_rd", {27'b0, dut.regfile_inst.waddr_i}, {27'b0, e.rd});
        check("wb_val", dut.regfile_inst.wdata_i, e.val);
      end
    end
  end

  function automatic logic [31:0] ei(input logic [11:0] imm, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, OPI};
  endfunction

  function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    exp_q.delete();
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] val);
    wr_t e;
    e.rd  = rd;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic start();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    rst    = 1'b0;
  endtask

  // Returns cycles from reset release until the halt flag is seen
  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!illegal && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("halt_seen", {31'b0, illegal}, 32'h1);
    repeat (6) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);
  endtask

  int cyc;
  logic [31:0] held_addr;

  initial begin
    // Reset state
    clear_rom();
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", instr_addr, 32'h0);
    check("rst_flag", {31'b0, illegal}, 32'h0);
    check("rst_dwe", {28'b0, data_we}, 32'h0);

    // ANDI
    clear_rom();
    rom[0] = ei(12'd13, 5'd0, 3'b000, 5'd5);
    rom[1] = ei(12'd7,  5'd5, 3'b111, 5'd5);
    expect_wr(5'd5, 32'd13);
    expect_wr(5'd5, 32'd5);
    start();
    wait_halt(cyc);
    check("halt_latency_ok", {31'b0, (cyc >= 4 && cyc <= 5)}, 32'h1);
    check("andi_x5", dut.regfile_inst.regfile[5], 32'd5);

    // Negative immediates
    clear_rom();
    rom[0] = ei(12'hFFF, 5'd0, 3'b000, 5'd1);
    rom[1] = ei(12'h0F0, 5'd1, 3'b111, 5'd2);
    rom[2] = ei(12'h800, 5'd0, 3'b110, 5'd3);
    expect_wr(5'd1, 32'hFFFF_FFFF);
    expect_wr(5'd2, 32'h0000_00F0);
    expect_wr(5'd3, 32'hFFFF_F800);
    start();
    wait_halt(cyc);
    check("neg_x3", dut.regfile_inst.regfile[3], 32'hFFFF_F800);

    // Shifts / compares
    clear_rom();
    rom[0] = ei(12'hFF8, 5'd0, 3'b000, 5'd1);
    rom[1] = ei({7'b0100000, 5'd1}, 5'd1, 3'b101, 5'd2);
    rom[2] = ei(12'd28, 5'd1, 3'b101, 5'd3);
    rom[3] = ei(12'd0,  5'd1, 3'b010, 5'd4);
    rom[4] = ei(12'd1,  5'd1, 3'b011, 5'd5);
    expect_wr(5'd1, 32'hFFFF_FFF8);
    expect_wr(5'd2, 32'hFFFF_FFFC);
    expect_wr(5'd3, 32'h0000_000F);
    expect_wr(5'd4, 32'h0000_0001);
    expect_wr(5'd5, 32'h0000_0000);
    start();
    wait_halt(cyc);

    // x0 and back-to-back dependencies
    clear_rom();
    rom[0] = ei(12'd5, 5'd0, 3'b000, 5'd0);
    rom[1] = ei(12'd3, 5'd0, 3'b000, 5'd6);
    rom[2] = er(7'b0000000, 5'd6, 5'd6, 3'b000, 5'd7);
    rom[3] = er(7'b0100000, 5'd7, 5'd0, 3'b000, 5'd8);
    expect_wr(5'd6, 32'd3);
    expect_wr(5'd7, 32'd6);
    expect_wr(5'd8, 32'hFFFF_FFFA);
    start();
    wait_halt(cyc);
    check("x0_zero", dut.regfile_inst.rdata1_o & 32'h0 | dut.regfile_inst.regfile[0], 32'h0);

    // R-type, LUI/AUIPC, then a store halts the core
    clear_rom();
    rom[0]  = {20'h80000, 5'd9, 7'b0110111};
    rom[1]  = {20'h00001, 5'd10, 7'b0010111};
    rom[2]  = ei(12'd3, 5'd0, 3'b000, 5'd11);
    rom[3]  = er(7'b0100000, 5'd11, 5'd9, 3'b101, 5'd12);
    rom[4]  = er(7'b0000000, 5'd11, 5'd9, 3'b101, 5'd13);
    rom[5]  = er(7'b0000000, 5'd11, 5'd11, 3'b001, 5'd14);
    rom[6]  = er(7'b0000000, 5'd11, 5'd9, 3'b010, 5'd15);
    rom[7]  = er(7'b0000000, 5'd11, 5'd9, 3'b011, 5'd16);
    rom[8]  = er(7'b0000000, 5'd11, 5'd9, 3'b100, 5'd17);
    rom[9]  = er(7'b0000000, 5'd11, 5'd10, 3'b110, 5'd18);
    rom[10] = er(7'b0000000, 5'd17, 5'd9, 3'b111, 5'd19);
    rom[11] = {7'b0, 5'd1, 5'd0, 3'b010, 5'b0, 7'b0100011};
    rom[12] = ei(12'd1, 5'd0, 3'b000, 5'd20);
    expect_wr(5'd9,  32'h8000_0000);
    expect_wr(5'd10, 32'h0000_1004);
    expect_wr(5'd11, 32'h0000_0003);
    expect_wr(5'd12, 32'hF000_0000);
    expect_wr(5'd13, 32'h1000_0000);
    expect_wr(5'd14, 32'h0000_0018);
    expect_wr(5'd15, 32'h0000_0001);
    expect_wr(5'd16, 32'h0000_0000);
    expect_wr(5'd17, 32'h8000_0003);
    expect_wr(5'd18, 32'h0000_1007);
    expect_wr(5'd19, 32'h8000_0000);
    start();
    wait_halt(cyc);
    held_addr = instr_addr;
    repeat (5) @(negedge clk);
    check("halt_pc_frozen", instr_addr, held_addr);
    check("halt_flag_sticky", {31'b0, illegal}, 32'h1);
    check("no_exec_after_illegal", dut.regfile_inst.regfile[20], 32'h0);
    check("data_addr_idle", data_addr, 32'h0);
    check("data_wdata_idle", data_wdata, 32'h0);

    // Reset mid-run, then identical re-execution
    clear_rom();
    rom[0] = ei(12'd5, 5'd0, 3'b000, 5'd0);
    rom[1] = ei(12'd3, 5'd0, 3'b000, 5'd6);
    rom[2] = er(7'b0000000, 5'd6, 5'd6, 3'b000, 5'd7);
    rom[3] = er(7'b0100000, 5'd7, 5'd0, 3'b000, 5'd8);
    start();
    mon_en = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun_x6", dut.regfile_inst.regfile[6], 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pc", instr_addr, 32'h0);
    check("midrst_x6", dut.regfile_inst.regfile[6], 32'h0);
    check("midrst_flag", {31'b0, illegal}, 32'h0);
    expect_wr(5'd6, 32'd3);
    expect_wr(5'd7, 32'd6);
    expect_wr(5'd8, 32'hFFFF_FFFA);
    mon_en = 1'b1;
    rst    = 1'b0;
    wait_halt(cyc);
    check("rerun_x8", dut.regfile_inst.regfile[8], 32'hFFFF_FFFA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jedro_1_top.md
Name: jedro_1_top

Overview:
- Minimal in-order RV32I integer core: 3 stages (IF, ID, EX/WB).
- Fetches from a synchronous-read instruction ROM and executes register-immediate, register-register, LUI and AUIPC instructions.
- Halts permanently on the first illegal or unsupported instruction.
- Top-level CPU block of the SoC; the data memory port is present but idle in this revision.

Parameters:
- DATA_WIDTH, 32, datapath and instruction width.
- ADDR_WIDTH, 32, instruction/data address width.
- BOOT_ADDR, 32'h0, PC value after reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- instr_addr_o  out  ADDR_WIDTH  byte address to instruction ROM.
- instr_rdata_i  in  DATA_WIDTH  ROM word for the address presented on the previous cycle (1-cycle latency).
- data_addr_o  out  ADDR_WIDTH  data RAM address; held 0.
- data_we_o  out  4  data RAM byte write enables; held 4'b0000.
- data_wdata_o  out  DATA_WIDTH  data RAM write data; held 0.
- data_rdata_i  in  DATA_WIDTH  data RAM read data; unused.
- illegal_instr_o  out  1  sticky halt flag (copy of decoder_inst.illegal_instr_ro).

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - PC=BOOT_ADDR, all pipeline valids 0, illegal flag 0, x1..x31=0.
  - All outputs as listed above.
  - Reset mid-operation discards in-flight instructions.
- IF:
  - instr_addr_o=PC.
  - PC+=4 each cycle while not halted.
  - The ROM word returns the next cycle; its valid bit follows the PC-issue cycle by one.
  - Instruction alignment: PC[1:0] always 00.
- ID:
  - Registers the instruction, valid bit, decoded opcode/funct3/funct7, rd/rs1/rs2 and sign-extended immediate.
  - Supported: OP-IMM (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI), OP (ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA), LUI, AUIPC.
  - Any other opcode, a bad funct3/funct7 combination, or the all-zero word is illegal.
  - Illegal instruction: sets illegal_instr_ro on the edge it is decoded. The flag is sticky until reset; fetch stops (PC frozen) and the illegal instruction is not executed.
  - Instructions decoded before it complete normally.
- EX/WB:
  - Reads rs1/rs2 combinationally from the regfile.
  - Computes the result in the ALU: 32-bit wrap-around; shifts use shamt[4:0]; SLT signed, SLTU unsigned.
  - Writes rd at the clock edge; writes to x0 are ignored, and x0 always reads 0.
- Latency:
  - Instruction at address A, issued cycle t → rdata at t+1 → decoded at t+2 → rd written at edge ending t+3.
  - Because operands are read in EX, back-to-back dependent instructions need no forwarding or stall.
- Throughput: 1 instruction/cycle; no branches, so no flushes.

Decomposition:
- Package jedro_1_pkg:
  - opcode constants (OPC_OP_IMM=7'b0010011, OPC_OP=7'b0110011, OPC_LUI, OPC_AUIPC);
  - ALU op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B);
  - funct3 constants.
- Sub-modules, with fixed instance names used by benches:
  - jedro_1_regfile, instance regfile_inst, storage array named regfile[0:31];
  - jedro_1_decoder, instance decoder_inst, exposing illegal_instr_ro.
- ALU inline in the top.

Test Plan:
- ANDI: program addi x5,x0,13; andi x5,x5,7; word 0 → illegal_instr_o rises about 4 cycles after reset release; 3 cycles later x5=5.
- Negative immediate: addi x1,x0,-1; andi x2,x1,0x0F0 → x1=32'hFFFFFFFF, x2=32'h000000F0; ori x3,x0,-2048 → x3=32'hFFFFF800.
- Shifts/compares: addi x1,x0,-8; srai x2,x1,1; srli x3,x1,28; slti x4,x1,0; sltiu x5,x1,1 → x2=FFFFFFFC, x3=0000000F, x4=1, x5=0.
- x0 and dependencies: addi x0,x0,5; addi x6,x0,3; add x7,x6,x6; sub x8,x0,x7 → x0=0, x7=6, x8=FFFFFFFA.
- Illegal halt: after a store opcode (unsupported), instr_addr_o stays constant, later words are not executed, and the flag stays 1 until rst_i.
- Reset mid-run: assert rst_i for 1 cycle during execution → PC=BOOT_ADDR, regs cleared, flag 0, and the program re-executes identically.
